// File: rtl/axi_mem_dp_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_dp_port_arbiter
// Description : Round-robin arbiter with bounded burst hold that shares one
//               single-port SRAM between the AXI write and read controllers.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_dp_port_arbiter #(
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int MEM_ADDR_WIDTH  = 13,
    parameter int AXI_NUMBYTES    = AXI4_DATA_WIDTH / 8,
    parameter int MAX_HOLD        = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid_i,
    output logic                       wr_grant_o,
    input  logic                       wr_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  wr_a_i,
    input  logic [AXI4_DATA_WIDTH-1:0] wr_d_i,
    input  logic [AXI_NUMBYTES-1:0]    wr_be_i,
    input  logic                       rd_valid_i,
    output logic                       rd_grant_o,
    input  logic                       rd_wen_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  rd_a_i,
    output logic [AXI4_DATA_WIDTH-1:0] rd_q_o,
    output logic                       rd_qvalid_o,
    output logic                       mem_cen_o,
    output logic                       mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_a_o,
    output logic [AXI4_DATA_WIDTH-1:0] mem_d_o,
    output logic [AXI_NUMBYTES-1:0]    mem_be_o,
    input  logic [AXI4_DATA_WIDTH-1:0] mem_q_i
);

    localparam int                  c_HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(MAX_HOLD);
    localparam logic                c_OWN_WR   = 1'b0;
    localparam logic                c_OWN_RD   = 1'b1;

    logic                r_owner;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_qvalid;
    logic                w_wr_gnt;
    logic                w_rd_gnt;
    logic                w_keep_owner;

    assign w_keep_owner = (r_hold < c_HOLD_MAX);

    // Under contention the owner keeps the port until its hold budget is spent.
    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        if (!rst) begin
            if (wr_valid_i && rd_valid_i) begin
                if ((r_owner == c_OWN_RD) == w_keep_owner) begin
                    w_rd_gnt = 1'b1;
                end else begin
                    w_wr_gnt = 1'b1;
                end
            end else begin
                w_wr_gnt = wr_valid_i;
                w_rd_gnt = rd_valid_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= c_OWN_RD;
            r_hold   <= '0;
            r_qvalid <= 1'b0;
        end else begin
            r_qvalid <= w_rd_gnt & rd_wen_i;
            if (w_wr_gnt || w_rd_gnt) begin
                // w_rd_gnt doubles as the winning side's owner encoding
                if (w_rd_gnt != r_owner) begin
                    r_owner <= w_rd_gnt ? c_OWN_RD : c_OWN_WR;
                    r_hold  <= c_HOLD_W'(1);
                end else if (r_hold != c_HOLD_MAX) begin
                    r_hold <= r_hold + 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_cen_o = 1'b1;
        mem_wen_o = 1'b1;
        mem_a_o   = '0;
        mem_d_o   = '0;
        mem_be_o  = '0;
        if (w_wr_gnt) begin
            mem_cen_o = 1'b0;
            mem_wen_o = wr_wen_i;
            mem_a_o   = wr_a_i;
            mem_d_o   = wr_d_i;
            mem_be_o  = wr_be_i;
        end else if (w_rd_gnt) begin
            mem_cen_o = 1'b0;
            mem_wen_o = rd_wen_i;
            mem_a_o   = rd_a_i;
            mem_be_o  = '1;
        end
    end

    assign wr_grant_o  = w_wr_gnt;
    assign rd_grant_o  = w_rd_gnt;
    assign rd_qvalid_o = r_qvalid;
    assign rd_q_o      = mem_q_i;

endmodule
`default_nettype wire
